// File: rtl/tower_target_if.sv
// VGA pixel-write port shared between the tower and the VGA arbiter.
interface tower_target_if;
    logic        vga_WriteEn;
    logic [14:0] vga_coords;
    logic [8:0]  vga_colour;

    modport master (
        output vga_WriteEn,
        output vga_coords,
        output vga_colour
    );

    modport slave (
        input vga_WriteEn,
        input vga_coords,
        input vga_colour
    );
endinterface

// File: rtl/tower_target.sv
// Defensive tower: latches a placement, draws its square sprite one pixel per
// cycle, scores hits on an in-range car once per frame tick with a frame-based
// cooldown, and pulses car_destroyed when the hit budget is used up.
module tower_target #(
    parameter int          SIZE            = 4,
    parameter int          RANGE           = 20,
    parameter int          COOLDOWN_FRAMES = 30,
    parameter int          HITS_TO_KILL    = 3,
    parameter logic [8:0]  TOWER_COLOUR    = 9'h1C0,
    parameter logic [8:0]  FIRE_COLOUR     = 9'h1FF
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           place,
    input  logic [7:0]     tower_x,
    input  logic [6:0]     tower_y,
    input  logic           frame_tick,
    input  logic [14:0]    car_location,
    input  logic           car_active,
    output logic           car_destroyed,
    output logic           draw_done,
    output logic [3:0]     hit_count,
    tower_target_if.master vga
);
    localparam int               LOG_S     = $clog2(SIZE);
    localparam int               PIX_W     = 2 * LOG_S;
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(SIZE * SIZE - 1);
    localparam logic [PIX_W-1:0] PIX_ZERO  = PIX_W'(0);
    localparam logic [7:0]       COOL_INIT = 8'(COOLDOWN_FRAMES);
    localparam logic [3:0]       HIT_LIMIT = 4'(HITS_TO_KILL);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAW     = 2'd1,
        S_ARMED    = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t           state_r;
    state_t           ret_r;
    logic [7:0]       tx_r;
    logic [6:0]       ty_r;
    logic [PIX_W-1:0] pix_r;
    logic [7:0]       cool_r;

    logic [7:0]       car_x_s;
    logic [6:0]       car_y_s;
    logic [8:0]       dx_s;
    logic [7:0]       dy_s;
    logic             hit_s;
    logic [3:0]       hit_inc_s;
    logic [PIX_W-1:0] pix_next_s;

    assign car_x_s = car_location[14:7];
    assign car_y_s = car_location[6:0];

    // Screen coordinate of sprite pixel k (row-major); sums wrap at 8/7 bits.
    function automatic logic [14:0] pixel_at(input logic [7:0] x,
                                             input logic [6:0] y,
                                             input logic [PIX_W-1:0] k);
        logic [7:0] col_v;
        logic [6:0] row_v;
        col_v = 8'(k) & 8'(SIZE - 1);
        row_v = 7'(k >> LOG_S);
        return {x + col_v, y + row_v};
    endfunction

    // Range test on the car position presented with this cycle's frame tick.
    always_comb begin
        dx_s       = (car_x_s >= tx_r) ? ({1'b0, car_x_s} - {1'b0, tx_r})
                                       : ({1'b0, tx_r} - {1'b0, car_x_s});
        dy_s       = (car_y_s >= ty_r) ? ({1'b0, car_y_s} - {1'b0, ty_r})
                                       : ({1'b0, ty_r} - {1'b0, car_y_s});
        hit_s      = frame_tick && car_active &&
                     (dx_s <= 9'(RANGE)) && (dy_s <= 8'(RANGE));
        hit_inc_s  = hit_count + 4'd1;
        pix_next_s = pix_r + PIX_W'(1);
    end

    // Tower sequencer: placement, sprite drawing, hit scoring and cooldown.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r         <= S_IDLE;
            ret_r           <= S_IDLE;
            tx_r            <= 8'd0;
            ty_r            <= 7'd0;
            pix_r           <= PIX_ZERO;
            cool_r          <= 8'd0;
            car_destroyed   <= 1'b0;
            draw_done       <= 1'b0;
            hit_count       <= 4'd0;
            vga.vga_WriteEn <= 1'b0;
            vga.vga_coords  <= 15'd0;
            vga.vga_colour  <= 9'd0;
        end else begin
            car_destroyed <= 1'b0;
            draw_done     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (place) begin
                        tx_r            <= tower_x;
                        ty_r            <= tower_y;
                        pix_r           <= PIX_ZERO;
                        ret_r           <= S_ARMED;
                        vga.vga_WriteEn <= 1'b1;
                        vga.vga_coords  <= pixel_at(tower_x, tower_y, PIX_ZERO);
                        vga.vga_colour  <= TOWER_COLOUR;
                        state_r         <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (pix_r == PIX_LAST) begin
                        vga.vga_WriteEn <= 1'b0;
                        draw_done       <= 1'b1;
                        state_r         <= ret_r;
                    end else begin
                        pix_r          <= pix_next_s;
                        vga.vga_coords <= pixel_at(tx_r, ty_r, pix_next_s);
                    end
                end
                S_ARMED: begin
                    if (hit_s) begin
                        cool_r <= COOL_INIT;
                        if (hit_inc_s == HIT_LIMIT) begin
                            car_destroyed <= 1'b1;
                            hit_count     <= 4'd0;
                        end else begin
                            hit_count <= hit_inc_s;
                        end
                        pix_r           <= PIX_ZERO;
                        ret_r           <= S_COOLDOWN;
                        vga.vga_WriteEn <= 1'b1;
                        vga.vga_coords  <= pixel_at(tx_r, ty_r, PIX_ZERO);
                        vga.vga_colour  <= FIRE_COLOUR;
                        state_r         <= S_DRAW;
                    end
                end
                S_COOLDOWN: begin
                    if (frame_tick) begin
                        cool_r <= cool_r - 8'd1;
                        if (cool_r == 8'd1) begin
                            pix_r           <= PIX_ZERO;
                            ret_r           <= S_ARMED;
                            vga.vga_WriteEn <= 1'b1;
                            vga.vga_coords  <= pixel_at(tx_r, ty_r, PIX_ZERO);
                            vga.vga_colour  <= TOWER_COLOUR;
                            state_r         <= S_DRAW;
                        end
                    end
                end
                default: begin
                    state_r         <= S_IDLE;
                    vga.vga_WriteEn <= 1'b0;
                end
            endcase
            // Losing the car forfeits its accumulated hits in every state.
            if (!car_active) begin
                hit_count <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_tower_target.sv
// Self-checking bench for tower_target: a queue-based behavioural model is
// compared against the DUT on every cycle, with directed literal checks for
// the placement draw, range boundaries, cooldown, kill pulse and reset.
module tb_tower_target;
    localparam int         SIZE = 4;
    localparam int         RNG  = 20;
    localparam int         COOL = 30;
    localparam int         HITS = 3;
    localparam logic [8:0] TC   = 9'h1C0;
    localparam logic [8:0] FC   = 9'h1FF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        place = 1'b0;
    logic [7:0]  tower_x = 8'd0;
    logic [6:0]  tower_y = 7'd0;
    logic        frame_tick = 1'b0;
    logic [14:0] car_location = 15'd0;
    logic        car_active = 1'b0;
    logic        car_destroyed;
    logic        draw_done;
    logic [3:0]  hit_count;

    tower_target_if vga_if ();

    tower_target #(
        .SIZE(SIZE), .RANGE(RNG), .COOLDOWN_FRAMES(COOL), .HITS_TO_KILL(HITS),
        .TOWER_COLOUR(TC), .FIRE_COLOUR(FC)
    ) dut (
        .clk(clk), .resetn(resetn), .place(place), .tower_x(tower_x),
        .tower_y(tower_y), .frame_tick(frame_tick), .car_location(car_location),
        .car_active(car_active), .car_destroyed(car_destroyed),
        .draw_done(draw_done), .hit_count(hit_count), .vga(vga_if.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [14:0] pend_xy[$];
    logic [8:0]  pend_col[$];
    bit          m_placed, m_cooling;
    int          m_cool_left, m_hits, m_tx, m_ty;
    logic        e_we, e_done, e_kill;
    logic [14:0] e_xy;
    logic [8:0]  e_col;
    logic [3:0]  e_hits;

    function automatic bit near(input int cx, input int cy, input int tx, input int ty);
        int dx, dy;
        dx = cx - tx; if (dx < 0) dx = -dx;
        dy = cy - ty; if (dy < 0) dy = -dy;
        return (dx <= RNG) && (dy <= RNG);
    endfunction

    task automatic start_sprite(input logic [8:0] col);
        logic [7:0] xx;
        logic [6:0] yy;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                xx = 8'(m_tx + c);
                yy = 7'(m_ty + r);
                pend_xy.push_back({xx, yy});
                pend_col.push_back(col);
            end
        end
        e_xy  = pend_xy.pop_front();
        e_col = pend_col.pop_front();
        e_we  = 1'b1;
    endtask

    // Expected outputs after each clock edge, from the behavioural rules.
    always @(posedge clk) begin
        if (!resetn) begin
            pend_xy.delete(); pend_col.delete();
            m_placed = 0; m_cooling = 0; m_cool_left = 0; m_hits = 0;
            m_tx = 0; m_ty = 0;
            e_we = 0; e_done = 0; e_kill = 0; e_xy = 0; e_col = 0; e_hits = 0;
        end else begin
            e_done = 0;
            e_kill = 0;
            if (e_we) begin
                if (pend_xy.size() != 0) begin
                    e_xy  = pend_xy.pop_front();
                    e_col = pend_col.pop_front();
                end else begin
                    e_we   = 0;
                    e_done = 1;
                end
            end else if (!m_placed) begin
                if (place) begin
                    m_placed = 1;
                    m_tx = int'(tower_x);
                    m_ty = int'(tower_y);
                    start_sprite(TC);
                end
            end else if (!m_cooling) begin
                if (frame_tick && car_active &&
                    near(int'(car_location[14:7]), int'(car_location[6:0]), m_tx, m_ty)) begin
                    m_hits++;
                    if (m_hits == HITS) begin
                        e_kill = 1;
                        m_hits = 0;
                    end
                    m_cooling   = 1;
                    m_cool_left = COOL;
                    start_sprite(FC);
                end
            end else if (frame_tick) begin
                m_cool_left--;
                if (m_cool_left == 0) begin
                    m_cooling = 0;
                    start_sprite(TC);
                end
            end
            if (!car_active) m_hits = 0;
            e_hits = 4'(m_hits);
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            cmp("we", 32'(vga_if.vga_WriteEn), 32'(e_we));
            cmp("draw_done", 32'(draw_done), 32'(e_done));
            cmp("car_destroyed", 32'(car_destroyed), 32'(e_kill));
            cmp("hit_count", 32'(hit_count), 32'(e_hits));
            if (e_we) begin
                cmp("coords", 32'(vga_if.vga_coords), 32'(e_xy));
                cmp("colour", 32'(vga_if.vga_colour), 32'(e_col));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int          w_cnt, d_cnt, d_at;
    logic [14:0] w_first, w_last;
    logic [8:0]  w_col;

    task automatic watch(input int n);
        w_cnt = 0; d_cnt = 0; d_at = 0; w_first = 0; w_last = 0; w_col = 0;
        for (int i = 1; i <= n; i++) begin
            if (vga_if.vga_WriteEn === 1'b1) begin
                if (w_cnt == 0) begin
                    w_first = vga_if.vga_coords;
                    w_col   = vga_if.vga_colour;
                end
                w_last = vga_if.vga_coords;
                w_cnt++;
            end
            if (draw_done === 1'b1) begin
                d_cnt++;
                d_at = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic tick(input logic [7:0] cx, input logic [6:0] cy);
        car_location = {cx, cy};
        frame_tick   = 1'b1;
        @(negedge clk);
        frame_tick   = 1'b0;
    endtask

    task automatic cool(input int n);
        w_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick(8'd0, 7'd0);
            if (vga_if.vga_WriteEn === 1'b1) w_cnt++;
            @(negedge clk);
            if (vga_if.vga_WriteEn === 1'b1) w_cnt++;
        end
    endtask

    task automatic cool_full();
        cool(COOL - 1);
        tick(8'd0, 7'd0);
        watch(18);
        cmp("redraw_writes", 32'(w_cnt), 32'd16);
        cmp("redraw_colour", 32'(w_col), 32'(TC));
    endtask

    task automatic do_place(input logic [7:0] x, input logic [6:0] y);
        tower_x = x;
        tower_y = y;
        place   = 1'b1;
        @(negedge clk);
        place   = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check_en = 1'b1;
        cmp("rst_we", 32'(vga_if.vga_WriteEn), 32'd0);
        cmp("rst_coords", 32'(vga_if.vga_coords), 32'd0);
        cmp("rst_colour", 32'(vga_if.vga_colour), 32'd0);
        cmp("rst_hits", 32'(hit_count), 32'd0);
        resetn = 1'b1;
        car_active = 1'b1;
        @(negedge clk);

        // Placement draw at (40,30).
        do_place(8'd40, 7'd30);
        watch(20);
        cmp("place_writes", 32'(w_cnt), 32'd16);
        cmp("place_first", 32'(w_first), 32'({8'd40, 7'd30}));
        cmp("place_last", 32'(w_last), 32'({8'd43, 7'd33}));
        cmp("place_colour", 32'(w_col), 32'(TC));
        cmp("place_done_cnt", 32'(d_cnt), 32'd1);
        cmp("place_done_at", 32'(d_at), 32'd17);

        // First hit at the diagonal corner of the range.
        tick(8'd60, 7'd50);
        cmp("hit1_count", 32'(hit_count), 32'd1);
        cmp("hit1_nokill", 32'(car_destroyed), 32'd0);
        watch(18);
        cmp("fire_writes", 32'(w_cnt), 32'd16);
        cmp("fire_colour", 32'(w_col), 32'(FC));
        cool(COOL - 1);
        cmp("cool29_no_redraw", 32'(w_cnt), 32'd0);
        tick(8'd0, 7'd0);
        watch(18);
        cmp("cool30_redraw", 32'(w_cnt), 32'd16);
        cmp("cool30_colour", 32'(w_col), 32'(TC));

        // Range boundary: dx=21 misses, dx=dy=20 hits.
        tick(8'd61, 7'd30);
        watch(3);
        cmp("dx21_no_writes", 32'(w_cnt), 32'd0);
        cmp("dx21_hits", 32'(hit_count), 32'd1);
        tick(8'd20, 7'd10);
        cmp("dx20_hits", 32'(hit_count), 32'd2);
        watch(18);
        cool_full();

        // Third hit destroys the car.
        tick(8'd40, 7'd30);
        cmp("kill_pulse", 32'(car_destroyed), 32'd1);
        cmp("kill_hits_zero", 32'(hit_count), 32'd0);
        @(negedge clk);
        cmp("kill_one_cycle", 32'(car_destroyed), 32'd0);
        watch(17);
        cool_full();

        // Two hits, then losing the car clears the count.
        tick(8'd40, 7'd30);
        watch(18);
        cool_full();
        tick(8'd40, 7'd30);
        cmp("two_hits", 32'(hit_count), 32'd2);
        watch(18);
        car_active = 1'b0;
        @(negedge clk);
        cmp("inactive_clears", 32'(hit_count), 32'd0);
        car_active = 1'b1;
        cool_full();

        // Placement while armed is ignored.
        do_place(8'd100, 7'd100);
        watch(5);
        cmp("place_ignored", 32'(w_cnt), 32'd0);
        tick(8'd40, 7'd30);
        watch(18);
        cmp("pos_fixed", 32'(w_first), 32'({8'd40, 7'd30}));

        // Reset in the middle of a draw.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_place(8'd10, 7'd5);
        repeat (7) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        cmp("midrst_we", 32'(vga_if.vga_WriteEn), 32'd0);
        cmp("midrst_coords", 32'(vga_if.vga_coords), 32'd0);
        cmp("midrst_colour", 32'(vga_if.vga_colour), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        cmp("midrst_quiet", 32'(vga_if.vga_WriteEn), 32'd0);
        do_place(8'd10, 7'd5);
        cmp("redraw_pix0", 32'(vga_if.vga_coords), 32'({8'd10, 7'd5}));
        watch(18);
        cmp("redraw_full", 32'(w_cnt), 32'd16);

        // Randomised traffic around the tower, with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            resetn     = ($urandom_range(0, 799) != 0);
            place      = ($urandom_range(0, 29) == 0);
            tower_x    = 8'($urandom_range(0, 255));
            tower_y    = 7'($urandom_range(0, 127));
            frame_tick = ($urandom_range(0, 2) == 0);
            car_active = ($urandom_range(0, 59) != 0);
            car_location = {8'(m_tx + $urandom_range(0, 50) - 25),
                            7'(m_ty + $urandom_range(0, 50) - 25)};
            @(negedge clk);
        end
        place = 1'b0;
        frame_tick = 1'b0;
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
